// File: rtl/trap_seq.sv
// Trap/MRET/WFI sequencer: latches the event, flushes and drains the pipeline,
// then holds a redirect to fetch until accepted.
module trap_seq #(
    parameter int PC_WIDTH      = 32,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trapped,
    input  logic                mret,
    input  logic                wfi,
    input  logic [PC_WIDTH-1:0] ecp,
    input  logic [3:0]          ecause,
    input  logic                interupt,
    input  logic [PC_WIDTH-1:0] mtvec,
    input  logic [PC_WIDTH-1:0] mepc,
    input  logic                pipe_empty,
    input  logic                redirect_ready,
    output logic                flush,
    output logic                commit_stall,
    output logic                csr_trap_we,
    output logic                csr_mret_we,
    output logic [PC_WIDTH-1:0] csr_epc,
    output logic [4:0]          csr_cause,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                drain_timeout,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WFI, S_FLUSH, S_DRAIN, S_REDIRECT
    } state_t;

    typedef enum logic {K_MRET, K_TRAP} kind_t;

    localparam logic [7:0] CNT_LAST = 8'(DRAIN_TIMEOUT - 1);

    state_t              r_state, w_nxt;
    kind_t               r_kind;
    logic [PC_WIDTH-1:0] r_epc, r_target;
    logic [4:0]          r_cause;
    logic [7:0]          r_cnt;
    logic                r_drain_to;

    logic                w_take_trap, w_take_mret, w_timeout;
    logic [PC_WIDTH-1:0] w_base, w_trap_tgt;

    // Vectored mode only offsets interrupts; exceptions always go to the base.
    assign w_base     = {mtvec[PC_WIDTH-1:2], 2'b00};
    assign w_trap_tgt = (mtvec[1:0] == 2'b01 && interupt)
                      ? w_base + PC_WIDTH'({ecause, 2'b00}) : w_base;

    always_comb begin
        w_nxt       = r_state;
        w_take_trap = 1'b0;
        w_take_mret = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (trapped) begin
                    w_take_trap = 1'b1;
                    w_nxt       = S_FLUSH;
                end else if (mret) begin
                    w_take_mret = 1'b1;
                    w_nxt       = S_FLUSH;
                end else if (wfi) begin
                    w_nxt = S_WFI;
                end
            end
            S_WFI: begin
                if (trapped) begin
                    w_take_trap = 1'b1;
                    w_nxt       = S_FLUSH;
                end
            end
            S_FLUSH: w_nxt = S_DRAIN;
            S_DRAIN: begin
                if (pipe_empty) begin
                    w_nxt = S_REDIRECT;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_nxt     = S_REDIRECT;
                end
            end
            S_REDIRECT: if (redirect_ready) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_kind     <= K_MRET;
            r_epc      <= '0;
            r_cause    <= '0;
            r_target   <= '0;
            r_cnt      <= '0;
            r_drain_to <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_drain_to <= w_timeout;
            if (w_take_trap) begin
                r_kind   <= K_TRAP;
                r_cause  <= {interupt, ecause};
                r_target <= w_trap_tgt;
                // A WFI wake keeps the EPC captured when WFI committed.
                if (r_state == S_IDLE) r_epc <= ecp;
            end
            if (w_take_mret) begin
                r_kind   <= K_MRET;
                r_target <= mepc;
            end
            if (r_state == S_IDLE && !trapped && !mret && wfi) r_epc <= ecp;
            if (r_state == S_FLUSH) r_cnt <= '0;
            else if (r_state == S_DRAIN && !pipe_empty) r_cnt <= r_cnt + 8'd1;
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign commit_stall   = busy;
    assign flush          = (r_state == S_FLUSH) || (r_state == S_DRAIN);
    assign csr_trap_we    = (r_state == S_FLUSH) && (r_kind == K_TRAP);
    assign csr_mret_we    = (r_state == S_FLUSH) && (r_kind == K_MRET);
    assign redirect_valid = (r_state == S_REDIRECT);
    assign redirect_pc    = redirect_valid ? r_target : '0;
    assign csr_epc        = r_epc;
    assign csr_cause      = r_cause;
    assign drain_timeout  = r_drain_to;

endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq: a cycle-level reference model checked every
// cycle, plus literal expectations from the worked scenarios.
module tb_trap_seq;

    localparam int TO = 15;
    localparam int P_IDLE = 0, P_WFI = 1, P_FLUSH = 2, P_DRAIN = 3, P_REDIR = 4;

    logic        clk = 1'b0;
    logic        rst, trapped, mret, wfi, interupt, pipe_empty, redirect_ready;
    logic [31:0] ecp, mtvec, mepc;
    logic [3:0]  ecause;
    logic        flush, commit_stall, csr_trap_we, csr_mret_we;
    logic        redirect_valid, drain_timeout, busy;
    logic [31:0] csr_epc, redirect_pc;
    logic [4:0]  csr_cause;

    int n_chk = 0;
    int n_fail = 0;

    trap_seq #(.PC_WIDTH(32), .DRAIN_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .trapped(trapped), .mret(mret), .wfi(wfi),
        .ecp(ecp), .ecause(ecause), .interupt(interupt), .mtvec(mtvec),
        .mepc(mepc), .pipe_empty(pipe_empty), .redirect_ready(redirect_ready),
        .flush(flush), .commit_stall(commit_stall), .csr_trap_we(csr_trap_we),
        .csr_mret_we(csr_mret_we), .csr_epc(csr_epc), .csr_cause(csr_cause),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .drain_timeout(drain_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] trap_target(input logic [31:0] tv, input logic [3:0] c,
                                                 input logic irq);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
        if (tv[1:0] == 2'b01 && irq) return base + 32'(c) * 4;
        return base;
    endfunction

    // Reference model: which phase of the sequence we are in and what was captured.
    int          m_phase = P_IDLE;
    int          m_waited = 0;
    bit          m_live = 0, m_trap = 0, m_to = 0;
    logic [31:0] m_epc = '0, m_target = '0;
    logic [4:0]  m_cause = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_phase = P_IDLE; m_trap = 0; m_to = 0; m_waited = 0;
            m_epc = '0; m_target = '0; m_cause = '0;
        end else begin
            m_to = 0;
            case (m_phase)
                P_IDLE:
                    if (trapped) begin
                        m_epc = ecp; m_cause = {interupt, ecause};
                        m_target = trap_target(mtvec, ecause, interupt);
                        m_trap = 1; m_phase = P_FLUSH;
                    end else if (mret) begin
                        m_target = mepc; m_trap = 0; m_phase = P_FLUSH;
                    end else if (wfi) begin
                        m_epc = ecp; m_phase = P_WFI;
                    end
                P_WFI:
                    if (trapped) begin
                        m_cause = {interupt, ecause};
                        m_target = trap_target(mtvec, ecause, interupt);
                        m_trap = 1; m_phase = P_FLUSH;
                    end
                P_FLUSH: begin m_waited = 0; m_phase = P_DRAIN; end
                P_DRAIN:
                    if (pipe_empty) m_phase = P_REDIR;
                    else begin
                        m_waited++;
                        if (m_waited == TO) begin m_to = 1; m_phase = P_REDIR; end
                    end
                P_REDIR: if (redirect_ready) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_busy", 32'(busy), 32'(m_phase != P_IDLE));
            check("m_stall", 32'(commit_stall), 32'(m_phase != P_IDLE));
            check("m_flush", 32'(flush), 32'(m_phase == P_FLUSH || m_phase == P_DRAIN));
            check("m_trap_we", 32'(csr_trap_we), 32'(m_phase == P_FLUSH && m_trap));
            check("m_mret_we", 32'(csr_mret_we), 32'(m_phase == P_FLUSH && !m_trap));
            check("m_rvalid", 32'(redirect_valid), 32'(m_phase == P_REDIR));
            check("m_rpc", redirect_pc, (m_phase == P_REDIR) ? m_target : 32'h0);
            check("m_dto", 32'(drain_timeout), 32'(m_to));
            check("m_epc", csr_epc, m_epc);
            check("m_cause", 32'(csr_cause), 32'(m_cause));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1; trapped = 0; mret = 0; wfi = 0; interupt = 0;
        pipe_empty = 1; redirect_ready = 1;
        ecp = '0; mtvec = '0; mepc = '0; ecause = '0;
        tick; tick;
        check("rst_busy", 32'(busy), 0);
        check("rst_epc", csr_epc, 0);
        rst = 0;

        // Direct trap, fastest path
        mtvec = 32'h100; ecp = 32'h2000; ecause = 4'd2; interupt = 0; trapped = 1;
        tick; trapped = 0;
        check("t1_trap_we", 32'(csr_trap_we), 1);
        check("t1_epc", csr_epc, 32'h2000);
        check("t1_cause", 32'(csr_cause), 32'h02);
        tick; check("t1_flush", 32'(flush), 1);
        tick; check("t1_rvalid", 32'(redirect_valid), 1);
        check("t1_rpc", redirect_pc, 32'h100);
        tick; check("t1_idle", 32'(busy), 0);

        // Vectored interrupt
        mtvec = 32'h101; ecause = 4'd7; interupt = 1; trapped = 1;
        tick; trapped = 0;
        check("t2_cause", 32'(csr_cause), 32'h17);
        tick; tick;
        check("t2_rpc", redirect_pc, 32'h11C);
        tick;

        // MRET with drain timeout
        pipe_empty = 0; mepc = 32'h3004; mret = 1;
        tick; mret = 0;
        check("t3_mret_we", 32'(csr_mret_we), 1);
        check("t3_trap_we", 32'(csr_trap_we), 0);
        k = 0;
        while (!drain_timeout && k < 40) begin tick; k++; end
        check("t3_to_lat", 32'(k), 32'd16);
        check("t3_rpc", redirect_pc, 32'h3004);
        pipe_empty = 1;
        tick; check("t3_idle", 32'(busy), 0);

        // WFI wake
        ecp = 32'h404; wfi = 1;
        tick; wfi = 0; ecp = 32'h999;
        for (int i = 0; i < 10; i++) begin
            check("t4_stall", 32'(commit_stall & busy & ~flush), 1);
            tick;
        end
        ecause = 4'd11; interupt = 1; mtvec = 32'h200; trapped = 1;
        tick; trapped = 0;
        check("t4_epc", csr_epc, 32'h404);
        check("t4_cause", 32'(csr_cause), 32'h1B);
        tick; tick;
        check("t4_rpc", redirect_pc, 32'h200);
        tick;

        // Priority, ignored trap during DRAIN, redirect backpressure
        mtvec = 32'h300; ecause = 4'd3; interupt = 0; mepc = 32'h5000; ecp = 32'h6000;
        pipe_empty = 0; redirect_ready = 0;
        trapped = 1; mret = 1; wfi = 1;
        tick; trapped = 0; mret = 0; wfi = 0;
        check("t5_trap_we", 32'(csr_trap_we), 1);
        check("t5_mret_we", 32'(csr_mret_we), 0);
        tick; trapped = 1; mtvec = 32'h700; ecause = 4'd9;
        tick; trapped = 0; pipe_empty = 1;
        tick;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_v", 32'(redirect_valid), 1);
            check("t5_hold_pc", redirect_pc, 32'h300);
            tick;
        end
        check("t5_cause", 32'(csr_cause), 32'h03);
        redirect_ready = 1;
        tick; check("t5_idle", 32'(busy), 0);

        // Reset while draining, then a clean sequence
        mtvec = 32'h100; ecause = 4'd2; interupt = 0; ecp = 32'h2000;
        pipe_empty = 0; trapped = 1;
        tick; trapped = 0;
        tick; check("t6_drain", 32'(flush), 1);
        rst = 1;
        tick; rst = 0; pipe_empty = 1;
        check("t6_busy", 32'(busy), 0);
        check("t6_flush", 32'(flush), 0);
        check("t6_epc", csr_epc, 0);
        check("t6_cause", 32'(csr_cause), 0);
        trapped = 1;
        tick; trapped = 0;
        check("t6_trap_we", 32'(csr_trap_we), 1);
        tick; tick;
        check("t6_rpc", redirect_pc, 32'h100);
        tick; tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of all PC/address fields.
REQ-002 Parameter DRAIN_TIMEOUT, default 15, maximum DRAIN cycles before forced exit; range 1..255.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 trapped  in  1  exception or interrupt request from the exception controller.
REQ-006 mret  in  1  committed MRET.
REQ-007 wfi  in  1  committed WFI.
REQ-008 ecp  in  PC_WIDTH  exception PC; already PC+4 for WFI.
REQ-009 ecause  in  4  trap cause code.
REQ-010 interupt  in  1  1 = cause is an interrupt.
REQ-011 mtvec  in  PC_WIDTH  trap vector CSR; bits[1:0] are the mode (01 = vectored).
REQ-012 mepc  in  PC_WIDTH  MRET return address.
REQ-013 pipe_empty  in  1  pipeline drained after flush.
REQ-014 redirect_ready  in  1  fetch accepts redirect.
REQ-015 flush  out  1  pipeline flush request.
REQ-016 commit_stall  out  1  block further ROB commit.
REQ-017 csr_trap_we  out  1  one-cycle strobe: write mepc/mcause/mstatus trap update.
REQ-018 csr_mret_we  out  1  one-cycle strobe: mstatus MRET update.
REQ-019 csr_epc  out  PC_WIDTH  latched EPC for the CSR write.
REQ-020 csr_cause  out  5  latched {interupt, ecause}.
REQ-021 redirect_valid  out  1  redirect request to fetch.
REQ-022 redirect_pc  out  PC_WIDTH  redirect target.
REQ-023 drain_timeout  out  1  one-cycle strobe when DRAIN is exited by timeout.
REQ-024 busy  out  1  state != IDLE.

Function
REQ-025 FSM states: IDLE, WFI, FLUSH, DRAIN, REDIRECT. All outputs are registered or decoded from state plus latched registers; no input-to-output combinational path.
REQ-026 IDLE event priority: trapped > mret > wfi. Events are sampled only in IDLE, plus trapped in WFI; they are ignored in every other state.
REQ-027 IDLE & trapped -> FLUSH.
  - Latch csr_epc=ecp and csr_cause={interupt,ecause}.
  - Latch target: vectored mode (mtvec[1:0]==01) with interupt=1 gives {mtvec[PC_WIDTH-1:2],2'b00} + 4*ecause; otherwise {mtvec[PC_WIDTH-1:2],2'b00}.
  - Arithmetic is modulo 2^PC_WIDTH.
  - Set kind=TRAP.
REQ-028 IDLE & mret -> FLUSH; target=mepc; kind=MRET.
REQ-029 IDLE & wfi -> WFI; latch csr_epc=ecp.
REQ-030 WFI state:
  - commit_stall=1, flush=0.
  - On trapped: latch csr_cause and target per REQ-027, keep the WFI-latched csr_epc, kind=TRAP, -> FLUSH.
REQ-031 FLUSH state (exactly 1 cycle):
  - flush=1, commit_stall=1.
  - csr_trap_we=1 if kind=TRAP, else csr_mret_we=1.
  - Clear the drain counter; -> DRAIN.
REQ-032 DRAIN state:
  - flush=1, commit_stall=1.
  - pipe_empty=1 -> REDIRECT.
  - Otherwise increment the counter; when the counter reaches DRAIN_TIMEOUT, assert drain_timeout for one cycle and -> REDIRECT.
  - pipe_empty takes precedence over timeout in the same cycle.
REQ-033 REDIRECT state:
  - redirect_valid=1, redirect_pc=target, commit_stall=1, flush=0.
  - redirect_valid and redirect_pc are held stable until redirect_ready=1; that cycle -> IDLE.
REQ-034 Minimum trap-to-redirect latency: event in IDLE at cycle N gives FLUSH at N+1, DRAIN at N+2, and redirect_valid at N+3 if pipe_empty is already 1 at N+2.
REQ-035 csr_trap_we and csr_mret_we are never high in the same cycle, and each is high for exactly one cycle per sequence.
REQ-036 In IDLE: flush, commit_stall, redirect_valid, csr_*_we and drain_timeout are all 0.

Reset
REQ-037 rst=1 at any edge, including mid-sequence, forces IDLE next cycle.
REQ-038 On reset, all outputs, csr_epc, csr_cause, target, kind and the drain counter are set to 0.
REQ-039 An in-flight redirect or strobe is abandoned on reset and is not replayed.

Verification
REQ-040 Direct trap: mtvec=0x100, ecp=0x2000, ecause=2, interupt=0, trapped pulse, pipe_empty=1, redirect_ready=1 -> csr_trap_we at N+1, csr_epc=0x2000, csr_cause=0x02, redirect_pc=0x100 at N+3, IDLE at N+4.
REQ-041 Vectored interrupt: mtvec=0x101, ecause=7, interupt=1 -> redirect_pc=0x11C, csr_cause=0x17.
REQ-042 MRET with drain timeout: mepc=0x3004, pipe_empty held 0 -> csr_mret_we pulse, drain_timeout after 15 DRAIN cycles, redirect_pc=0x3004.
REQ-043 WFI wake: wfi with ecp=0x404; wait 10 cycles (commit_stall=1, busy=1); then trapped with ecause=11, interupt=1, mtvec=0x200 -> csr_epc=0x404, csr_cause=0x1B, redirect_pc=0x200.
REQ-044 Priority and backpressure: trapped, mret and wfi together -> trap path taken; redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stable for those cycles; a trapped pulse during DRAIN is ignored.
REQ-045 Reset in DRAIN: rst=1 -> next cycle IDLE with all outputs 0; a subsequent trap sequences normally.
